// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// cache_mem_arbiter : I/D-cache miss-path arbiter for the 256-bit memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic         i_resp,
  output logic [255:0] i_rdata,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic         d_resp,
  output logic [255:0] d_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic         mem_resp,
  input  logic [255:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t         state_q;
  logic           mem_read_q;
  logic           mem_write_q;
  logic [31:0]    mem_address_q;
  logic [255:0]   mem_wdata_q;
  logic           d_req;
  logic           grant_d_d;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;  // 1 = D won the previous arbitration

  assign grant_d_d = d_req & (~i_read | ~last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b0;
    end else if (state_q == IDLE && (d_req || i_read)) begin
      last_grant_q <= grant_d_d;
    end
  end
`else
  assign grant_d_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d_d) begin
            // A simultaneous read+write request is serviced as a write-back.
            state_q       <= SERVE_D;
            mem_read_q    <= ~d_write;
            mem_write_q   <= d_write;
            mem_address_q <= d_address;
            mem_wdata_q   <= d_wdata;
          end else if (i_read) begin
            state_q       <= SERVE_I;
            mem_read_q    <= 1'b1;
            mem_write_q   <= 1'b0;
            mem_address_q <= i_address;
            mem_wdata_q   <= d_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state_q     <= GAP;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  assign i_resp  = (state_q == SERVE_I) & mem_resp;
  assign d_resp  = (state_q == SERVE_D) & mem_resp;
  assign i_rdata = (state_q == SERVE_I) ? mem_rdata : '0;
  assign d_rdata = (state_q == SERVE_D) ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
// tb_cache_mem_arbiter : directed self-checking bench for cache_mem_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [31:0]  i_address;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic         mem_resp;
  logic [255:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] C_A5 = {32{8'hA5}};
  localparam logic [255:0] C_W1 = {8{32'h1234_5678}};
  localparam logic [255:0] C_R1 = {8{32'hCAFE_0001}};

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_resp      (i_resp),
    .i_rdata     (i_rdata),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_resp      (d_resp),
    .d_rdata     (d_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; mem_resp = 0; mem_rdata = '0;
    tick(); tick();
    smp();
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
    total++; if (mem_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    total++; if ({i_resp, d_resp} !== 2'b00) begin bad++; $display("FAIL reset_resp got=%b exp=00", {i_resp, d_resp}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lone_i();
    i_read = 1; i_address = 32'h0000_0060;
    tick();
    smp();
    total++; if ({mem_read, mem_write} !== 2'b10) begin bad++; $display("FAIL lone_i_strobe got=%b exp=10", {mem_read, mem_write}); end
    total++; if (mem_address !== 32'h60) begin bad++; $display("FAIL lone_i_addr got=%h exp=60", mem_address); end
    for (int c = 0; c < 3; c++) begin
      tick(); smp();
      total++; if (mem_read !== 1'b1 || mem_address !== 32'h60 || i_resp !== 1'b0) begin bad++; $display("FAIL lone_i_hold cyc=%0d rd=%b addr=%h resp=%b exp=1,60,0", c, mem_read, mem_address, i_resp); end
    end
    tick(); mem_resp = 1; mem_rdata = C_A5;
    smp();
    total++; if (i_resp !== 1'b1) begin bad++; $display("FAIL lone_i_resp got=%b exp=1", i_resp); end
    total++; if (i_rdata !== C_A5) begin bad++; $display("FAIL lone_i_rdata got=%h exp=%h", i_rdata, C_A5); end
    total++; if (d_resp !== 1'b0 || d_rdata !== '0) begin bad++; $display("FAIL lone_i_dside got=%b/%h exp=0/0", d_resp, d_rdata); end
    tick(); mem_resp = 0; i_read = 0;
    smp();
    total++; if (mem_read !== 1'b0 || i_resp !== 1'b0 || i_rdata !== '0) begin bad++; $display("FAIL lone_i_gap rd=%b resp=%b rdata=%h exp=0,0,0", mem_read, i_resp, i_rdata); end
    tick();
  endtask

  task automatic test_d_writeback();
    d_write = 1; d_address = 32'h0000_1000; d_wdata = C_W1;
    tick(); smp();
    total++; if ({mem_read, mem_write} !== 2'b01) begin bad++; $display("FAIL wb_strobe got=%b exp=01", {mem_read, mem_write}); end
    total++; if (mem_address !== 32'h1000 || mem_wdata !== C_W1) begin bad++; $display("FAIL wb_latch addr=%h wdata=%h exp=1000,%h", mem_address, mem_wdata, C_W1); end
    tick(); d_address = 32'h0000_2000; d_wdata = ~C_W1; d_read = 1;
    for (int c = 0; c < 2; c++) begin
      smp();
      total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h1000 || mem_wdata !== C_W1 || d_resp !== 1'b0) begin bad++; $display("FAIL wb_hold cyc=%0d wr=%b rd=%b addr=%h wdata=%h resp=%b", c, mem_write, mem_read, mem_address, mem_wdata, d_resp); end
      tick();
    end
    mem_resp = 1; mem_rdata = C_R1;
    smp();
    total++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin bad++; $display("FAIL wb_resp d=%b i=%b exp=1,0", d_resp, i_resp); end
    tick(); mem_resp = 0; d_read = 0; d_write = 0;
    smp();
    total++; if (d_resp !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL wb_after resp=%b wr=%b exp=0,0", d_resp, mem_write); end
    tick();
  endtask

  // Three simultaneous request pairs; expected grant order D, I, D, I, D, I.
  task automatic test_simultaneous();
    for (int p = 0; p < 3; p++) begin
      d_read = 1; d_address = 32'h0000_2000 + 32'(p) * 32'h40;
      i_read = 1; i_address = 32'h0000_3000 + 32'(p) * 32'h40;
      for (int g = 0; g < 2; g++) begin
        tick(); smp();
        if (g == 0) begin
          total++; if (mem_read !== 1'b1 || mem_address !== d_address) begin bad++; $display("FAIL sim_grant_d pair=%0d rd=%b addr=%h exp=1,%h", p, mem_read, mem_address, d_address); end
        end else begin
          total++; if (mem_read !== 1'b1 || mem_address !== i_address) begin bad++; $display("FAIL sim_grant_i pair=%0d rd=%b addr=%h exp=1,%h", p, mem_read, mem_address, i_address); end
        end
        tick(); mem_resp = 1; mem_rdata = C_R1 ^ 256'(p);
        smp();
        total++; if ({d_resp, i_resp} !== ((g == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL sim_resp pair=%0d g=%0d got d,i=%b", p, g, {d_resp, i_resp}); end
        tick(); mem_resp = 0;
        if (g == 0) d_read = 0; else i_read = 0;
        smp();
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL sim_gap pair=%0d g=%0d rd=%b exp=0", p, g, mem_read); end
        tick(); smp();
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL sim_idle pair=%0d g=%0d rd=%b exp=0", p, g, mem_read); end
        @(posedge clk); #1;
        if (g == 1) begin
          smp();
          total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL sim_regrant pair=%0d rd=%b exp=0", p, mem_read); end
        end
      end
    end
  endtask

  task automatic test_stale_i();
    i_read = 1; i_address = 32'h0000_0080;
    tick(); smp();
    total++; if (mem_read !== 1'b1 || mem_address !== 32'h80) begin bad++; $display("FAIL stale_grant rd=%b addr=%h exp=1,80", mem_read, mem_address); end
    tick(); mem_resp = 1; mem_rdata = C_A5;
    smp();
    total++; if (i_resp !== 1'b1) begin bad++; $display("FAIL stale_resp got=%b exp=1", i_resp); end
    tick(); mem_resp = 0;
    tick(); i_read = 0;
    for (int c = 0; c < 3; c++) begin
      smp();
      total++; if (mem_read !== 1'b0 || i_resp !== 1'b0) begin bad++; $display("FAIL stale_regrant cyc=%0d rd=%b resp=%b exp=0,0", c, mem_read, i_resp); end
      tick();
    end
  endtask

  task automatic test_idle_resp();
    mem_resp = 1; mem_rdata = C_A5;
    smp();
    total++; if ({i_resp, d_resp} !== 2'b00 || i_rdata !== '0 || d_rdata !== '0) begin bad++; $display("FAIL idle_resp got=%b exp=00", {i_resp, d_resp}); end
    tick(); mem_resp = 0;
    smp();
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL idle_resp_strobe got=%b exp=00", {mem_read, mem_write}); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    d_write = 1; d_address = 32'h0000_1040; d_wdata = C_W1;
    tick(); smp();
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rstmid_pre wr=%b exp=1", mem_write); end
    tick(); d_write = 0; #1;
    rst_n = 0; mem_resp = 1;
    #1;
    total++; if (mem_write !== 1'b0 || mem_address !== 32'h0 || mem_wdata !== '0) begin bad++; $display("FAIL rstmid_async wr=%b addr=%h exp=0,0", mem_write, mem_address); end
    total++; if (d_resp !== 1'b0) begin bad++; $display("FAIL rstmid_dresp got=%b exp=0", d_resp); end
    smp(); rst_n = 1; mem_resp = 0;
    tick(); smp();
    total++; if ({mem_read, mem_write, d_resp} !== 3'b000) begin bad++; $display("FAIL rstmid_idle got=%b exp=000", {mem_read, mem_write, d_resp}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_i();
    test_d_writeback();
    test_simultaneous();
    test_stale_i();
    test_idle_resp();
    test_reset_mid_write();
    test_lone_i();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
